// File: rtl/myip_sa_axi4_master_if.sv
// AXI4-full bus bundle between the systolic-array burst master and the memory-side slave.
// User signals are at least one bit wide even when the configured width is zero.
interface myip_sa_axi4_master_if #(
    parameter int ID_W     = 1,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 128,
    parameter int AWUSER_W = 1,
    parameter int WUSER_W  = 1,
    parameter int BUSER_W  = 1,
    parameter int ARUSER_W = 1,
    parameter int RUSER_W  = 1
);
    logic [ID_W-1:0]     awid;
    logic [ADDR_W-1:0]   awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                awlock;
    logic [3:0]          awcache;
    logic [2:0]          awprot;
    logic [3:0]          awqos;
    logic [AWUSER_W-1:0] awuser;
    logic                awvalid;
    logic                awready;

    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic [WUSER_W-1:0]  wuser;
    logic                wvalid;
    logic                wready;

    logic [ID_W-1:0]     bid;
    logic [1:0]          bresp;
    logic [BUSER_W-1:0]  buser;
    logic                bvalid;
    logic                bready;

    logic [ID_W-1:0]     arid;
    logic [ADDR_W-1:0]   araddr;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic                arlock;
    logic [3:0]          arcache;
    logic [2:0]          arprot;
    logic [3:0]          arqos;
    logic [ARUSER_W-1:0] aruser;
    logic                arvalid;
    logic                arready;

    logic [ID_W-1:0]     rid;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic [RUSER_W-1:0]  ruser;
    logic                rvalid;
    logic                rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awuser, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wuser, wvalid,
        input  wready,
        input  bid, bresp, buser, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, aruser, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, ruser, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awuser, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wuser, wvalid,
        output wready,
        output bid, bresp, buser, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, aruser, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, ruser, rvalid,
        input  rready
    );
endinterface

// File: rtl/myip_sa_axi4_master.sv
// AXI4-full burst master: one BURST_LEN-beat INCR burst per LOAD/STORE command from the SA controller.
// Optional macro SA_AXI_READ_CHECK_EN: compare each LOAD beat against c_m00_wdata + beat index.
module myip_sa_axi4_master #(
    parameter logic [31:0] C_M_TARGET_SLAVE_BASE_ADDR = 32'h4000_0000,
    parameter int C_M_AXI_BURST_LEN    = 16,
    parameter int C_M_AXI_ID_WIDTH     = 1,
    parameter int C_M_AXI_ADDR_WIDTH   = 32,
    parameter int C_M_AXI_DATA_WIDTH   = 128,
    parameter int C_M_AXI_AWUSER_WIDTH = 0,
    parameter int C_M_AXI_ARUSER_WIDTH = 0,
    parameter int C_M_AXI_WUSER_WIDTH  = 0,
    parameter int C_M_AXI_RUSER_WIDTH  = 0,
    parameter int C_M_AXI_BUSER_WIDTH  = 0
) (
    input  logic                          m00_axi_aclk,
    input  logic                          m00_axi_areset,
    input  logic [1:0]                    c_m00_mode,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] c_m00_off_mem_addra,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] c_m00_off_mem_addrb,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] c_m00_wdata,
    output logic [C_M_AXI_DATA_WIDTH-1:0] c_m00_rdata,
    input  logic                          m00_axi_init_axi_txn,
    output logic                          m00_axi_txn_done,
    output logic                          m00_axi_error,
    myip_sa_axi4_master_if.master         m00_axi
);
    localparam int ADDR_W   = C_M_AXI_ADDR_WIDTH;
    localparam int DATA_W   = C_M_AXI_DATA_WIDTH;
    localparam int BYTES    = DATA_W / 8;
    localparam int ADDR_LSB = $clog2(BYTES);
    localparam int AWU_W    = (C_M_AXI_AWUSER_WIDTH > 0) ? C_M_AXI_AWUSER_WIDTH : 1;
    localparam int ARU_W    = (C_M_AXI_ARUSER_WIDTH > 0) ? C_M_AXI_ARUSER_WIDTH : 1;
    localparam int WU_W     = (C_M_AXI_WUSER_WIDTH > 0)  ? C_M_AXI_WUSER_WIDTH  : 1;
    localparam int RU_W     = (C_M_AXI_RUSER_WIDTH > 0)  ? C_M_AXI_RUSER_WIDTH  : 1;
    localparam int BU_W     = (C_M_AXI_BUSER_WIDTH > 0)  ? C_M_AXI_BUSER_WIDTH  : 1;

    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(C_M_TARGET_SLAVE_BASE_ADDR);
    localparam logic [7:0]        LAST_BEAT = 8'(C_M_AXI_BURST_LEN - 1);
    localparam logic [1:0]        MODE_LOAD  = 2'b01;
    localparam logic [1:0]        MODE_STORE = 2'b10;

    typedef enum logic [2:0] {
        IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA, DONE
    } state_t;

    state_t state, state_nxt;

    logic              init_q;
    logic              start_ok;
    logic [7:0]        beat;
    logic              last_beat;
    logic              err;
    logic [DATA_W-1:0] rdata_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] beat_data_q;

    logic awvalid, wvalid, wlast, bready, arvalid, rready, txn_done;
    logic w_hs, b_hs, r_hs;
    logic rd_mismatch;
    logic fault;

    // A command is accepted only on a fresh init edge while idle and only for LOAD/STORE.
    assign start_ok  = m00_axi_init_axi_txn && !init_q && (state == IDLE) &&
                       ((c_m00_mode == MODE_LOAD) || (c_m00_mode == MODE_STORE));
    assign last_beat = (beat == LAST_BEAT);

    assign w_hs = wvalid && m00_axi.wready;
    assign b_hs = bready && m00_axi.bvalid;
    assign r_hs = rready && m00_axi.rvalid;

`ifdef SA_AXI_READ_CHECK_EN
    assign rd_mismatch = r_hs && (m00_axi.rdata != beat_data_q);
`else
    assign rd_mismatch = 1'b0;
`endif

    assign fault = (b_hs && m00_axi.bresp[1]) ||
                   (r_hs && (m00_axi.rresp[1] || (m00_axi.rlast != last_beat))) ||
                   rd_mismatch;

    always_ff @(posedge m00_axi_aclk or posedge m00_axi_areset) begin
        if (m00_axi_areset) begin
            state   <= IDLE;
            init_q  <= 1'b0;
            beat    <= 8'd0;
            err     <= 1'b0;
            rdata_q <= '0;
        end else begin
            state  <= state_nxt;
            init_q <= m00_axi_init_axi_txn;
            if (start_ok) begin
                beat <= 8'd0;
            end else if (w_hs || r_hs) begin
                beat <= beat + 8'd1;
            end
            if (start_ok) begin
                err <= 1'b0;
            end else if (fault) begin
                err <= 1'b1;
            end
            if (r_hs) begin
                rdata_q <= m00_axi.rdata;
            end
        end
    end

    // Burst address and running beat pattern; only meaningful while a burst is in flight.
    always_ff @(posedge m00_axi_aclk) begin
        if (start_ok) begin
            addr_q      <= BASE + (((c_m00_mode == MODE_STORE) ? c_m00_off_mem_addra
                                                               : c_m00_off_mem_addrb) << ADDR_LSB);
            beat_data_q <= c_m00_wdata;
        end else if (w_hs || r_hs) begin
            beat_data_q <= beat_data_q + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        awvalid   = 1'b0;
        wvalid    = 1'b0;
        wlast     = 1'b0;
        bready    = 1'b0;
        arvalid   = 1'b0;
        rready    = 1'b0;
        txn_done  = 1'b0;
        case (state)
            IDLE: begin
                if (start_ok) begin
                    state_nxt = (c_m00_mode == MODE_STORE) ? WR_ADDR : RD_ADDR;
                end
            end
            WR_ADDR: begin
                awvalid = 1'b1;
                if (m00_axi.awready) state_nxt = WR_DATA;
            end
            WR_DATA: begin
                wvalid = 1'b1;
                wlast  = last_beat;
                if (m00_axi.wready && last_beat) state_nxt = WR_RESP;
            end
            WR_RESP: begin
                bready = 1'b1;
                if (m00_axi.bvalid) state_nxt = DONE;
            end
            RD_ADDR: begin
                arvalid = 1'b1;
                if (m00_axi.arready) state_nxt = RD_DATA;
            end
            RD_DATA: begin
                rready = 1'b1;
                if (m00_axi.rvalid && (m00_axi.rlast || last_beat)) state_nxt = DONE;
            end
            DONE: begin
                txn_done = 1'b1;
                if (!m00_axi_init_axi_txn) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign m00_axi.awid    = '0;
    assign m00_axi.awaddr  = addr_q;
    assign m00_axi.awlen   = LAST_BEAT;
    assign m00_axi.awsize  = 3'(ADDR_LSB);
    assign m00_axi.awburst = 2'b01;
    assign m00_axi.awlock  = 1'b0;
    assign m00_axi.awcache = 4'b0010;
    assign m00_axi.awprot  = 3'b000;
    assign m00_axi.awqos   = 4'b0000;
    assign m00_axi.awuser  = {AWU_W{1'b0}};
    assign m00_axi.awvalid = awvalid;

    assign m00_axi.wdata   = beat_data_q;
    assign m00_axi.wstrb   = {BYTES{1'b1}};
    assign m00_axi.wlast   = wlast;
    assign m00_axi.wuser   = {WU_W{1'b0}};
    assign m00_axi.wvalid  = wvalid;

    assign m00_axi.bready  = bready;

    assign m00_axi.arid    = '0;
    assign m00_axi.araddr  = addr_q;
    assign m00_axi.arlen   = LAST_BEAT;
    assign m00_axi.arsize  = 3'(ADDR_LSB);
    assign m00_axi.arburst = 2'b01;
    assign m00_axi.arlock  = 1'b0;
    assign m00_axi.arcache = 4'b0010;
    assign m00_axi.arprot  = 3'b000;
    assign m00_axi.arqos   = 4'b0000;
    assign m00_axi.aruser  = {ARU_W{1'b0}};
    assign m00_axi.arvalid = arvalid;

    assign m00_axi.rready  = rready;

    assign c_m00_rdata      = rdata_q;
    assign m00_axi_txn_done = txn_done;
    assign m00_axi_error    = err;

    logic [C_M_AXI_ID_WIDTH-1:0] unused_bid;
    logic [C_M_AXI_ID_WIDTH-1:0] unused_rid;
    logic [BU_W-1:0]             unused_buser;
    logic [RU_W-1:0]             unused_ruser;
    logic [1:0]                  unused_resp_lsb;
    assign unused_bid      = m00_axi.bid;
    assign unused_rid      = m00_axi.rid;
    assign unused_buser    = m00_axi.buser;
    assign unused_ruser    = m00_axi.ruser;
    assign unused_resp_lsb = {m00_axi.bresp[0], m00_axi.rresp[0]};
endmodule

// File: tb/tb_myip_sa_axi4_master.sv
// Directed bench for myip_sa_axi4_master against a BRAM-like AXI4 slave model with optional stalls and faults.
module tb_myip_sa_axi4_master;
    localparam logic [31:0] BASE = 32'h4000_0000;
    localparam logic [1:0] M_IDLE = 2'b00, M_LOAD = 2'b01, M_STORE = 2'b10, M_RSVD = 2'b11;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]   mode  = 2'b00;
    logic [31:0]  addra = '0;
    logic [31:0]  addrb = '0;
    logic [127:0] wdata = '0;
    logic [127:0] rdata_o;
    logic         init  = 1'b0;
    logic         done;
    logic         err;

    myip_sa_axi4_master_if #(.ID_W(1), .ADDR_W(32), .DATA_W(128)) axi ();

    myip_sa_axi4_master #(
        .C_M_TARGET_SLAVE_BASE_ADDR(BASE),
        .C_M_AXI_BURST_LEN(16),
        .C_M_AXI_ID_WIDTH(1),
        .C_M_AXI_ADDR_WIDTH(32),
        .C_M_AXI_DATA_WIDTH(128)
    ) dut (
        .m00_axi_aclk(clk),
        .m00_axi_areset(rst),
        .c_m00_mode(mode),
        .c_m00_off_mem_addra(addra),
        .c_m00_off_mem_addrb(addrb),
        .c_m00_wdata(wdata),
        .c_m00_rdata(rdata_o),
        .m00_axi_init_axi_txn(init),
        .m00_axi_txn_done(done),
        .m00_axi_error(err),
        .m00_axi(axi)
    );

    // Slave model state
    logic         stall_en = 1'b0, bresp_fault = 1'b0, corrupt_en = 1'b0;
    logic [127:0] mem [0:255];
    logic [127:0] wlog [0:15];
    int           aw_idx, wbeat, wlast_beat, ar_idx, rbeat, r_acc, act_cnt, stab_err, w_early;
    logic         aw_seen, b_pend, r_active;
    logic [31:0]  aw_addr_q, ar_addr_q;
    logic [7:0]   aw_len_q;
    logic [2:0]   aw_size_q;
    logic [1:0]   aw_burst_q;
    logic         aw_stall, w_stall, ar_stall, wl_prev;
    logic [31:0]  aw_addr_prev, ar_addr_prev;
    logic [127:0] wd_prev;

    assign axi.bid   = '0;
    assign axi.buser = '0;
    assign axi.rid   = '0;
    assign axi.ruser = '0;
    assign axi.rresp = 2'b00;

    always @(posedge clk) begin : slave
        int nxt;
        if (rst) begin
            axi.awready <= 1'b0; axi.wready <= 1'b0; axi.bvalid <= 1'b0; axi.bresp <= 2'b00;
            axi.arready <= 1'b0; axi.rvalid <= 1'b0; axi.rlast <= 1'b0; axi.rdata <= '0;
            aw_seen <= 1'b0; b_pend <= 1'b0; r_active <= 1'b0;
            aw_idx <= 0; wbeat <= 0; wlast_beat <= -1; ar_idx <= 0; rbeat <= 0; r_acc <= 0;
            act_cnt <= 0; stab_err <= 0; w_early <= 0;
            aw_stall <= 1'b0; w_stall <= 1'b0; ar_stall <= 1'b0;
        end else begin
            // stability of master-driven channels while stalled
            if (aw_stall && !(axi.awvalid && axi.awaddr == aw_addr_prev)) stab_err <= stab_err + 1;
            if (w_stall && !(axi.wvalid && axi.wdata == wd_prev && axi.wlast == wl_prev)) stab_err <= stab_err + 1;
            if (ar_stall && !(axi.arvalid && axi.araddr == ar_addr_prev)) stab_err <= stab_err + 1;
            aw_stall <= axi.awvalid && !axi.awready; aw_addr_prev <= axi.awaddr;
            w_stall  <= axi.wvalid && !axi.wready;   wd_prev <= axi.wdata; wl_prev <= axi.wlast;
            ar_stall <= axi.arvalid && !axi.arready; ar_addr_prev <= axi.araddr;
            if (axi.awvalid || axi.wvalid || axi.arvalid) act_cnt <= act_cnt + 1;

            axi.awready <= stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
            if (axi.awvalid && axi.awready) begin
                aw_addr_q <= axi.awaddr; aw_len_q <= axi.awlen;
                aw_size_q <= axi.awsize; aw_burst_q <= axi.awburst;
                aw_idx <= int'((axi.awaddr - BASE) >> 4);
                aw_seen <= 1'b1; wbeat <= 0; wlast_beat <= -1;
            end

            axi.wready <= stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
            if (axi.wvalid && !aw_seen) w_early <= w_early + 1;
            if (axi.wvalid && axi.wready) begin
                if (aw_idx + wbeat < 256) mem[aw_idx + wbeat] <= axi.wdata;
                if (wbeat < 16) wlog[wbeat[3:0]] <= axi.wdata;
                if (axi.wlast && wlast_beat < 0) wlast_beat <= wbeat;
                if (axi.wlast) begin b_pend <= 1'b1; aw_seen <= 1'b0; end
                wbeat <= wbeat + 1;
            end

            if (axi.bvalid && axi.bready) begin
                axi.bvalid <= 1'b0;
            end else if (b_pend && !axi.bvalid) begin
                axi.bvalid <= 1'b1;
                axi.bresp  <= bresp_fault ? 2'b10 : 2'b00;
                b_pend     <= 1'b0;
            end

            nxt = rbeat + ((axi.rvalid && axi.rready) ? 1 : 0);
            if (axi.rvalid && axi.rready) r_acc <= r_acc + 1;
            if (!axi.rvalid || axi.rready) begin
                if (r_active && nxt < 16 && (!stall_en || $urandom_range(0, 1) == 1)) begin
                    axi.rvalid <= 1'b1;
                    axi.rdata  <= mem[ar_idx + nxt] ^ ((corrupt_en && nxt == 5) ? 128'd1 : 128'd0);
                    axi.rlast  <= (nxt == 15);
                end else begin
                    axi.rvalid <= 1'b0;
                    axi.rlast  <= 1'b0;
                end
                rbeat <= nxt;
            end

            axi.arready <= stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
            if (axi.arvalid && axi.arready) begin
                ar_addr_q <= axi.araddr;
                ar_idx    <= int'((axi.araddr - BASE) >> 4);
                rbeat     <= 0;
                r_acc     <= 0;
                r_active  <= 1'b1;
            end
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic run_txn(input string tag, input logic [1:0] m, input logic [31:0] a, input logic [127:0] d);
        int cyc;
        @(negedge clk);
        mode = m;
        if (m == M_STORE) addra = a; else addrb = a;
        wdata = d;
        init  = 1'b1;
        cyc = 0;
        while (!done && cyc < 3000) begin @(negedge clk); cyc++; end
        chk({tag, "_done"}, done, 1'b1);
        init = 1'b0;
        cyc = 0;
        while (done && cyc < 20) begin @(negedge clk); cyc++; end
        @(negedge clk);
    endtask

    initial begin
        int cyc;
        int bad;
        logic [127:0] d;
        logic         exp_err;

        // reset held for two cycles
        repeat (2) @(negedge clk);
        chk("rst_awvalid", axi.awvalid, 1'b0);
        chk("rst_wvalid",  axi.wvalid,  1'b0);
        chk("rst_arvalid", axi.arvalid, 1'b0);
        chk("rst_bready_rready", {axi.bready, axi.rready, axi.wlast}, 3'b000);
        chk("rst_done",    done,    1'b0);
        chk("rst_error",   err,     1'b0);
        chk("rst_rdata",   rdata_o, 128'd0);
        rst = 1'b0;

        // IDLE and reserved modes must not start anything
        @(negedge clk);
        mode = M_IDLE; init = 1'b1;
        repeat (10) @(negedge clk);
        chk("idle_activity", act_cnt, 0);
        chk("idle_done", done, 1'b0);
        init = 1'b0; mode = M_RSVD;
        @(negedge clk);
        init = 1'b1;
        repeat (10) @(negedge clk);
        chk("mode11_activity", act_cnt, 0);
        init = 1'b0;
        @(negedge clk);

        // single STORE
        run_txn("store240", M_STORE, 32'd240, 128'd57600);
        chk("store240_awaddr", aw_addr_q, 32'h4000_0F00);
        chk("store240_awlen", aw_len_q, 8'd15);
        chk("store240_awsize_burst", {aw_size_q, aw_burst_q}, {3'd4, 2'b01});
        chk("store240_beat0", wlog[0], 128'd57600);
        chk("store240_beat15", wlog[15], 128'd57615);
        chk("store240_nbeats", wbeat, 16);
        chk("store240_wlast_pos", wlast_beat, 15);
        chk("store240_error", err, 1'b0);

        // STORE sweep then LOAD sweep
        for (int a = 240; a >= 0; a -= 16) run_txn("sweep_st", M_STORE, 32'(a), 128'(a * a));
        for (int a = 0; a <= 240; a += 16) begin
            run_txn("sweep_ld", M_LOAD, 32'(a), 128'(a * a));
            chk("sweep_ld_rdata", rdata_o, 128'(a * a + 15));
            chk("sweep_ld_error", err, 1'b0);
        end

        // random slave stalls, pattern wrapping past 2^128
        stall_en = 1'b1;
        d = {128{1'b1}} - 128'd7;
        run_txn("stall_st", M_STORE, 32'd32, d);
        bad = 0;
        for (int k = 0; k < 16; k++) if (wlog[k] !== d + 128'(k)) bad++;
        chk("stall_st_beats", bad, 0);
        chk("stall_st_nbeats", wbeat, 16);
        chk("stall_st_wlast_pos", wlast_beat, 15);
        chk("stall_st_w_before_aw", w_early, 0);
        run_txn("stall_ld", M_LOAD, 32'd32, d);
        chk("stall_ld_araddr", ar_addr_q, 32'h4000_0200);
        chk("stall_ld_rdata", rdata_o, 128'd7);
        chk("stall_ld_nbeats", r_acc, 16);
        chk("stall_ld_error", err, 1'b0);
        chk("stall_stability", stab_err, 0);
        stall_en = 1'b0;

        // BRESP slave error, then cleared by the next accepted start
        bresp_fault = 1'b1;
        run_txn("bresp_err", M_STORE, 32'd64, 128'd5);
        chk("bresp_err_error", err, 1'b1);
        bresp_fault = 1'b0;
        run_txn("bresp_clr", M_STORE, 32'd64, 128'd5);
        chk("bresp_clr_error", err, 1'b0);

        // corrupted read beat 5
`ifdef SA_AXI_READ_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        corrupt_en = 1'b1;
        run_txn("corrupt", M_LOAD, 32'd0, 128'd0);
        chk("corrupt_error", err, exp_err);
        chk("corrupt_rdata", rdata_o, 128'd15);
        corrupt_en = 1'b0;

        // reset in the middle of a write burst
        @(negedge clk);
        mode = M_STORE; addra = 32'd128; wdata = 128'd1; init = 1'b1;
        cyc = 0;
        while (!axi.wvalid && cyc < 200) begin @(negedge clk); cyc++; end
        chk("midrst_reached_wdata", axi.wvalid, 1'b1);
        rst = 1'b1;
        #1;
        chk("midrst_valids", {axi.awvalid, axi.wvalid, axi.arvalid, axi.wlast, axi.bready, axi.rready}, 6'd0);
        chk("midrst_done_err", {done, err}, 2'b00);
        chk("midrst_rdata", rdata_o, 128'd0);
        init = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("midrst_no_completion", {done, axi.awvalid, axi.wvalid}, 3'b000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
